regfile_wb_arbiter: RTL and testbench

//   Shares the single register-file write port between two writeback sources: the ALU pipe and the load/memory pipe.
//   - Each source has its own small FIFO; round-robin arbitration drains the FIFOs.
//   - A registered write command drives the register file's reg_write_en/rd_addr/rd_data.
//   - Exports a pending-write bitmask so decode can stall on RAW against queued writebacks.

---
 rtl/regfile_wb_arbiter.sv | 218 +++++++++++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
//   Shares the single register-file write port between the ALU writeback pipe and the
//   load/memory writeback pipe. Each source has a small FIFO. A round-robin arbiter drains
//   the FIFO heads into a registered write command (reg_write_en/rd_addr/rd_data).
//   pending_busy flags every register with a queued or in-flight write, so decode can stall
//   on RAW hazards.
//
// Ports
//   clk, reset            single clock; synchronous active-high reset
//   flush                 drops all queued/pending writes; the round-robin pointer is kept
//   alu_valid/ready/rd/data  ALU writeback request channel
//   mem_valid/ready/rd/data  load writeback request channel
//   reg_write_en, rd_addr, rd_data  registered register-file write command
//   pending_busy          bit i set while a write to xi is queued or in the output register
//   stat_*                (WB_ARB_STATS_EN only) saturating grant / conflict counters
//
// Configuration: define WB_ARB_STATS_EN to add the statistics counters and ports.

module regfile_wb_arbiter #(
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  alu_valid,
    output logic                  alu_ready,
    input  logic [ADDR_WIDTH-1:0] alu_rd,
    input  logic [DATA_WIDTH-1:0] alu_data,
    input  logic                  mem_valid,
    output logic                  mem_ready,
    input  logic [ADDR_WIDTH-1:0] mem_rd,
    input  logic [DATA_WIDTH-1:0] mem_data,
    output logic                  reg_write_en,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
`ifdef WB_ARB_STATS_EN
    output logic [31:0]           stat_alu_grants,
    output logic [31:0]           stat_mem_grants,
    output logic [31:0]           stat_conflicts,
`endif
    output logic [31:0]           pending_busy
);

    localparam int unsigned IW = $clog2(FIFO_DEPTH);
    localparam int unsigned PW = IW + 1;

    // Source index 0 = ALU, 1 = MEM.
    logic [PW-1:0]         wr_ptr_q [2];
    logic [PW-1:0]         wr_ptr_d [2];
    logic [PW-1:0]         rd_ptr_q [2];
    logic [PW-1:0]         rd_ptr_d [2];
    logic [ADDR_WIDTH-1:0] ent_rd_q   [2][FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] ent_rd_d   [2][FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] ent_data_q [2][FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] ent_data_d [2][FIFO_DEPTH];

    // Set when the last grant went to ALU; reset value makes MEM win the first tie.
    logic                  last_alu_q, last_alu_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;

    logic [1:0]            in_valid, full, nonempty, push, grant;
    logic [ADDR_WIDTH-1:0] in_rd   [2];
    logic [DATA_WIDTH-1:0] in_data [2];

    always_comb begin
        in_valid   = {mem_valid, alu_valid};
        in_rd[0]   = alu_rd;
        in_rd[1]   = mem_rd;
        in_data[0] = alu_data;
        in_data[1] = mem_data;
        full       = '0;
        nonempty   = '0;
        push       = '0;
        for (int s = 0; s < 2; s++) begin
            full[s]     = (wr_ptr_q[s][IW] != rd_ptr_q[s][IW]) &&
                          (wr_ptr_q[s][IW-1:0] == rd_ptr_q[s][IW-1:0]);
            nonempty[s] = (wr_ptr_q[s] != rd_ptr_q[s]);
            // rd==0 requests complete the handshake but are never stored.
            push[s]     = in_valid[s] && !full[s] && (in_rd[s] != '0) && !flush;
        end
    end

    assign alu_ready = !full[0];
    assign mem_ready = !full[1];

    always_comb begin
        grant = '0;
        if (!flush) begin
            if (nonempty[1] && (!nonempty[0] || last_alu_q)) begin
                grant[1] = 1'b1;
            end else if (nonempty[0]) begin
                grant[0] = 1'b1;
            end
        end
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        ent_rd_d   = ent_rd_q;
        ent_data_d = ent_data_q;
        last_alu_d = last_alu_q;
        we_d       = 1'b0;
        addr_d     = addr_q;
        data_d     = data_q;
        for (int s = 0; s < 2; s++) begin
            if (push[s]) begin
                ent_rd_d[s][wr_ptr_q[s][IW-1:0]]   = in_rd[s];
                ent_data_d[s][wr_ptr_q[s][IW-1:0]] = in_data[s];
                wr_ptr_d[s] = wr_ptr_q[s] + PW'(1);
            end
            if (grant[s]) begin
                rd_ptr_d[s] = rd_ptr_q[s] + PW'(1);
                we_d        = 1'b1;
                addr_d      = ent_rd_q[s][rd_ptr_q[s][IW-1:0]];
                data_d      = ent_data_q[s][rd_ptr_q[s][IW-1:0]];
                last_alu_d  = (s == 0);
            end
        end
        if (flush) begin
            for (int s = 0; s < 2; s++) begin
                wr_ptr_d[s] = '0;
                rd_ptr_d[s] = '0;
            end
            we_d   = 1'b0;
            addr_d = '0;
            data_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < 2; s++) begin
                wr_ptr_q[s] <= '0;
                rd_ptr_q[s] <= '0;
            end
            last_alu_q <= 1'b1;
            we_q       <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            last_alu_q <= last_alu_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
        end
    end

    // Entry storage needs no reset: only slots between the pointers are ever read.
    always_ff @(posedge clk) begin
        ent_rd_q   <= ent_rd_d;
        ent_data_q <= ent_data_d;
    end

    assign reg_write_en = we_q;
    assign rd_addr      = addr_q;
    assign rd_data      = data_q;

    always_comb begin
        logic [PW-1:0] cnt;
        logic [IW-1:0] idx;
        pending_busy = '0;
        cnt          = '0;
        idx          = '0;
        for (int s = 0; s < 2; s++) begin
            cnt = wr_ptr_q[s] - rd_ptr_q[s];
            for (int k = 0; k < FIFO_DEPTH; k++) begin
                idx = rd_ptr_q[s][IW-1:0] + IW'(k);
                if (PW'(k) < cnt) begin
                    pending_busy = pending_busy | (32'(1) << ent_rd_q[s][idx]);
                end
            end
        end
        if (we_q) begin
            pending_busy = pending_busy | (32'(1) << addr_q);
        end
        pending_busy[0] = 1'b0;
    end

`ifdef WB_ARB_STATS_EN
    logic [31:0] stat_alu_q, stat_alu_d;
    logic [31:0] stat_mem_q, stat_mem_d;
    logic [31:0] stat_cfl_q, stat_cfl_d;

    always_comb begin
        stat_alu_d = stat_alu_q;
        stat_mem_d = stat_mem_q;
        stat_cfl_d = stat_cfl_q;
        if (grant[0] && (stat_alu_q != '1)) stat_alu_d = stat_alu_q + 32'd1;
        if (grant[1] && (stat_mem_q != '1)) stat_mem_d = stat_mem_q + 32'd1;
        if ((&nonempty) && (stat_cfl_q != '1)) stat_cfl_d = stat_cfl_q + 32'd1;
    end

    // Cleared by reset only; flush leaves the statistics intact.
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_alu_q <= '0;
            stat_mem_q <= '0;
            stat_cfl_q <= '0;
        end else begin
            stat_alu_q <= stat_alu_d;
            stat_mem_q <= stat_mem_d;
            stat_cfl_q <= stat_cfl_d;
        end
    end

    assign stat_alu_grants = stat_alu_q;
    assign stat_mem_grants = stat_mem_q;
    assign stat_conflicts  = stat_cfl_q;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed self-checking bench for regfile_wb_arbiter (default parameters).
// Inputs change and outputs are sampled on the falling clock edge.

module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        reset, flush;
    logic        alu_valid, alu_ready, mem_valid, mem_ready;
    logic [4:0]  alu_rd, mem_rd, rd_addr;
    logic [63:0] alu_data, mem_data, rd_data;
    logic        reg_write_en;
    logic [31:0] pending_busy;
`ifdef WB_ARB_STATS_EN
    logic [31:0] stat_alu_grants, stat_mem_grants, stat_conflicts;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    regfile_wb_arbiter dut (
        .clk          (clk),
        .reset        (reset),
        .flush        (flush),
        .alu_valid    (alu_valid),
        .alu_ready    (alu_ready),
        .alu_rd       (alu_rd),
        .alu_data     (alu_data),
        .mem_valid    (mem_valid),
        .mem_ready    (mem_ready),
        .mem_rd       (mem_rd),
        .mem_data     (mem_data),
        .reg_write_en (reg_write_en),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
`ifdef WB_ARB_STATS_EN
        .stat_alu_grants (stat_alu_grants),
        .stat_mem_grants (stat_mem_grants),
        .stat_conflicts  (stat_conflicts),
`endif
        .pending_busy (pending_busy)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        flush     = 1'b0;
        alu_valid = 1'b0;
        mem_valid = 1'b0;
        alu_rd    = '0;
        mem_rd    = '0;
        alu_data  = '0;
        mem_data  = '0;
    endtask

    task automatic both_valid(input logic [4:0] a_rd, input logic [4:0] m_rd);
        alu_valid = 1'b1;
        mem_valid = 1'b1;
        alu_rd    = a_rd;
        mem_rd    = m_rd;
        alu_data  = 64'hA0 + 64'(a_rd);
        mem_data  = 64'hB0 + 64'(m_rd);
    endtask

    // Leaves the bench at a falling edge with reset released and outputs at reset values.
    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        idle_inputs();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check_eq({tag, "_we"}, 64'(reg_write_en), 64'd0);
        check_eq({tag, "_addr"}, 64'(rd_addr), 64'd0);
        check_eq({tag, "_data"}, rd_data, 64'd0);
        check_eq({tag, "_pend"}, 64'(pending_busy), 64'd0);
        check_eq({tag, "_ardy"}, 64'(alu_ready), 64'd1);
        check_eq({tag, "_mrdy"}, 64'(mem_ready), 64'd1);
`ifdef WB_ARB_STATS_EN
        check_eq({tag, "_stat_alu"}, 64'(stat_alu_grants), 64'd0);
        check_eq({tag, "_stat_mem"}, 64'(stat_mem_grants), 64'd0);
        check_eq({tag, "_stat_cfl"}, 64'(stat_conflicts), 64'd0);
`endif
    endtask

    initial begin
        int          wr_cyc[$];
        logic [4:0]  wr_addr[$];
        logic [63:0] wr_dat[$];
        logic        seen_not_ready;
        logic        found;

        reset = 1'b1;
        idle_inputs();
        do_reset();
        check_reset_state("reset");

        // Single ALU write: pending from after E0, write visible after E1, gone after E2.
        alu_valid = 1'b1;
        alu_rd    = 5'd5;
        alu_data  = 64'hAA;
        @(negedge clk);
        idle_inputs();
        check_eq("t1_we_e0", 64'(reg_write_en), 64'd0);
        check_eq("t1_pend_e0", 64'(pending_busy), 64'h20);
        @(negedge clk);
        check_eq("t1_we_e1", 64'(reg_write_en), 64'd1);
        check_eq("t1_addr_e1", 64'(rd_addr), 64'd5);
        check_eq("t1_data_e1", rd_data, 64'hAA);
        check_eq("t1_pend_e1", 64'(pending_busy), 64'h20);
        @(negedge clk);
        check_eq("t1_we_e2", 64'(reg_write_en), 64'd0);
        check_eq("t1_pend_e2", 64'(pending_busy), 64'd0);

        // Both sources every cycle for 8 cycles: MEM,ALU,... one write per cycle.
        do_reset();
        seen_not_ready = 1'b0;
        for (int c = 0; c < 16; c++) begin
            if (reg_write_en) begin
                wr_cyc.push_back(c);
                wr_addr.push_back(rd_addr);
                wr_dat.push_back(rd_data);
            end
            if (c < 8) both_valid(5'd1, 5'd2);
            else idle_inputs();
            if (!alu_ready || !mem_ready) seen_not_ready = 1'b1;
            @(negedge clk);
        end
        check_eq("t2_nwrites", 64'(wr_cyc.size()), 64'd10);
        check_eq("t2_first_cycle", 64'(wr_cyc.size() > 0 ? wr_cyc[0] : -1), 64'd2);
        for (int i = 0; i < wr_cyc.size(); i++) begin
            check_eq($sformatf("t2_addr_%0d", i), 64'(wr_addr[i]), (i % 2 == 0) ? 64'd2 : 64'd1);
            check_eq($sformatf("t2_data_%0d", i), wr_dat[i], (i % 2 == 0) ? 64'hB2 : 64'hA1);
            check_eq($sformatf("t2_cycle_%0d", i), 64'(wr_cyc[i]), 64'(2 + i));
        end
        check_eq("t2_ready_dropped", 64'(seen_not_ready), 64'd1);

        // Three back-to-back ALU requests: ready stays high, writes in order.
        do_reset();
        wr_cyc.delete();
        wr_addr.delete();
        wr_dat.delete();
        for (int c = 0; c < 7; c++) begin
            if (reg_write_en) begin
                wr_cyc.push_back(c);
                wr_addr.push_back(rd_addr);
                wr_dat.push_back(rd_data);
            end
            if (c < 3) begin
                check_eq($sformatf("t3_ready_%0d", c), 64'(alu_ready), 64'd1);
                alu_valid = 1'b1;
                alu_rd    = 5'(3 + c);
                alu_data  = 64'h11 * 64'(c + 1);
            end else begin
                idle_inputs();
            end
            @(negedge clk);
        end
        check_eq("t3_nwrites", 64'(wr_cyc.size()), 64'd3);
        for (int i = 0; i < wr_cyc.size(); i++) begin
            check_eq($sformatf("t3_addr_%0d", i), 64'(wr_addr[i]), 64'(3 + i));
            check_eq($sformatf("t3_data_%0d", i), wr_dat[i], 64'h11 * 64'(i + 1));
            check_eq($sformatf("t3_cycle_%0d", i), 64'(wr_cyc[i]), 64'(2 + i));
        end

        // rd==0 is accepted but never written nor flagged.
        do_reset();
        check_eq("t4_ready", 64'(alu_ready), 64'd1);
        alu_valid = 1'b1;
        alu_rd    = 5'd0;
        alu_data  = 64'hFF;
        @(negedge clk);
        idle_inputs();
        for (int c = 0; c < 3; c++) begin
            check_eq($sformatf("t4_we_%0d", c), 64'(reg_write_en), 64'd0);
            check_eq($sformatf("t4_pend_%0d", c), 64'(pending_busy), 64'd0);
            @(negedge clk);
        end

        // Fill, then flush with new requests present in the flush cycle.
        do_reset();
        for (int c = 0; c < 4; c++) begin
            both_valid(5'd1, 5'd2);
            @(negedge clk);
        end
        check_eq("t5_pend_before", 64'(pending_busy), 64'h6);
        check_eq("t5_alu_full", 64'(alu_ready), 64'd0);
        flush = 1'b1;
        both_valid(5'd7, 5'd8);
        @(negedge clk);
        idle_inputs();
        check_eq("t5_we", 64'(reg_write_en), 64'd0);
        check_eq("t5_pend", 64'(pending_busy), 64'd0);
        check_eq("t5_ardy", 64'(alu_ready), 64'd1);
        check_eq("t5_mrdy", 64'(mem_ready), 64'd1);
        check_eq("t5_addr", 64'(rd_addr), 64'd0);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check_eq($sformatf("t5_after_we_%0d", c), 64'(reg_write_en), 64'd0);
        end

        // Reset mid-stream right after a MEM grant; MEM must still win the next tie.
        do_reset();
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            both_valid(5'd1, 5'd2);
            @(negedge clk);
            if (reg_write_en && rd_addr == 5'd2 && c > 1) found = 1'b1;
        end
        check_eq("t6_found_mem_write", 64'(found), 64'd1);
        reset = 1'b1;
        both_valid(5'd9, 5'd10);
        @(negedge clk);
        reset = 1'b0;
        check_reset_state("t6_reset");
        @(negedge clk);
        idle_inputs();
        check_eq("t6_we_lat", 64'(reg_write_en), 64'd0);
        @(negedge clk);
        check_eq("t6_first_we", 64'(reg_write_en), 64'd1);
        check_eq("t6_first_addr", 64'(rd_addr), 64'd10);
        @(negedge clk);
        check_eq("t6_second_addr", 64'(rd_addr), 64'd9);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
